// File: rtl/lcd_pkg.sv
// LCD executor op codes, the fixed power-up command ROM and the scheduler state type.
// Shared by the command scheduler and anything else that drives LCD_executor.
package lcd_pkg;

  localparam int INIT_ROM_LEN = 4;

  typedef enum logic [3:0] {
    OP_WRITE_CHAR = 4'd0,
    OP_SET_CURSOR = 4'd1,
    OP_CLEAR      = 4'd2,
    OP_HOME       = 4'd3,
    OP_RAW_CMD    = 4'd14,
    OP_NOP        = 4'd15
  } lcd_op_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
  } lcd_cmd_t;

  typedef enum logic [1:0] {
    INIT_ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    IDLE
  } sched_state_t;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam lcd_cmd_t INIT_ROM [INIT_ROM_LEN] = '{
    '{op: OP_RAW_CMD, data: 8'h38},
    '{op: OP_RAW_CMD, data: 8'h0C},
    '{op: OP_RAW_CMD, data: 8'h01},
    '{op: OP_RAW_CMD, data: 8'h06}
  };

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping modulo NREQ.
// Purely combinational; the caller owns and advances the pointer.
module lcd_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;
  int unsigned   pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IW'(pos);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Owns the LCD_executor command port: replays the power-up ROM, then round-robins requesters,
// one command outstanding at a time (accept in IDLE, exec_start one cycle later).
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int OP_W        = 4,
  parameter int DATA_W      = 8,
  parameter int INIT_LEN    = INIT_ROM_LEN,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ*OP_W-1:0]      req_op_i,
  input  logic [NREQ*DATA_W-1:0]    req_data_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [OP_W-1:0]           exec_op_o,
  output logic [DATA_W-1:0]         exec_data_o,
  output logic                      exec_start_o,
  input  logic                      exec_rdy_i,
  output logic                      init_done_o,
  output logic                      busy_o,
  output logic [$clog2(NREQ)-1:0]   grant_id_o,
  output logic                      ack_err_o
);

  localparam int IW   = $clog2(NREQ);
  localparam int RI_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int TW   = $clog2(ACK_TIMEOUT + 1);

  sched_state_t    state_q, state_d;
  logic [RI_W-1:0] rom_idx_q, rom_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic            start_q, start_d;
  logic            init_done_q, init_done_d;
  logic            ack_err_q, ack_err_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  lcd_cmd_t        rom_cmd;

  lcd_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign rom_cmd = INIT_ROM[rom_idx_q];

  always_comb begin
    state_d     = state_q;
    rom_idx_d   = rom_idx_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    op_d        = op_q;
    data_d      = data_q;
    start_d     = 1'b0;
    init_done_d = init_done_q;
    ack_err_d   = ack_err_q;
    tmo_d       = tmo_q;
    req_ready_o = '0;

    unique case (state_q)
      INIT_ISSUE: begin
        op_d    = OP_W'(rom_cmd.op);
        data_d  = DATA_W'(rom_cmd.data);
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_LOW;
      end
      // A start the executor never acknowledges must not wedge the port.
      WAIT_LOW: begin
        if (!exec_rdy_i) begin
          state_d = WAIT_HIGH;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = WAIT_HIGH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_HIGH: begin
        if (exec_rdy_i) begin
          if (!init_done_q && rom_idx_q != RI_W'(INIT_LEN - 1)) begin
            rom_idx_d = rom_idx_q + RI_W'(1);
            state_d   = INIT_ISSUE;
          end else begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      IDLE: begin
        if (init_done_q && exec_rdy_i && arb_any) begin
          req_ready_o = arb_gnt;
          op_d        = OP_W'(req_op_i >> (int'(arb_idx) * OP_W));
          data_d      = DATA_W'(req_data_i >> (int'(arb_idx) * DATA_W));
          start_d     = 1'b1;
          tmo_d       = '0;
          grant_id_d  = arb_idx;
          rr_ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d     = WAIT_LOW;
        end
      end
      default: state_d = INIT_ISSUE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT_ISSUE;
      rom_idx_q   <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      op_q        <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
      init_done_q <= 1'b0;
      ack_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rom_idx_q   <= rom_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      op_q        <= op_d;
      data_q      <= data_d;
      start_q     <= start_d;
      init_done_q <= init_done_d;
      ack_err_q   <= ack_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign exec_op_o    = op_q;
  assign exec_data_o  = data_q;
  assign exec_start_o = start_q;
  assign init_done_o  = init_done_q;
  assign busy_o       = (state_q != IDLE);
  assign grant_id_o   = grant_id_q;
  assign ack_err_o    = ack_err_q;

endmodule
